// File: rtl/sseg_address_capture_if.sv
// Seven-segment display bus plus decoded-address readback signals.
interface sseg_address_capture_if;
  logic [7:0] sseg_indicator;
  logic [3:0] digits;
  logic [8:0] address_value;
  logic       address_valid;
  logic       decode_error;
  logic       range_error;

  // Drives the display bus and observes the decode results.
  modport master (
    output sseg_indicator,
    output digits,
    input  address_value,
    input  address_valid,
    input  decode_error,
    input  range_error
  );

  // The decoder: listens to the display bus and reports addresses.
  modport slave (
    input  sseg_indicator,
    input  digits,
    output address_value,
    output address_valid,
    output decode_error,
    output range_error
  );
endinterface

// File: rtl/sseg_address_capture.sv
// Readback decoder for the multiplexed 3-digit address display: filters each
// strobe for stability, decodes segments to BCD and converts a full frame to binary.
module sseg_address_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  sseg_address_capture_if.slave bus
);

  typedef enum logic [1:0] {StCollect, StConv1, StConv2, StCheck} state_e;

  localparam logic [3:0] RunTarget = 4'(STABLE_CYCLES - 1);

  logic [10:0]      cur;
  logic [10:0]      prev_q;
  logic [3:0]       run_q, run_d;
  logic             captured_q;
  logic             same;
  logic             qualify;
  logic             seg_ok;
  logic [3:0]       seg_bcd;
  logic             slot_en;
  logic [1:0]       slot_idx;
  logic [2:0]       full_q, full_d;
  logic [2:0][3:0]  bcd_q, bcd_d;
  logic             frame_take;
  state_e           state_q;
  logic [3:0]       h_q, t_q, o_q;
  logic [6:0]       acc7_q;
  logic [9:0]       acc10_q;
  logic [8:0]       address_value_q;
  logic             address_valid_q;
  logic             decode_error_q;
  logic             range_error_q;
  logic             unused_dp;

  // The decimal point never carries address information.
  assign unused_dp = bus.sseg_indicator[7];

  assign cur  = {bus.digits, bus.sseg_indicator[6:0]};
  assign same = (cur == prev_q);

  // Run length of the current bus value, saturating at 15.
  always_comb begin
    run_d = 4'd0;
    if (same) begin
      run_d = (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
    end
  end

  // RunTarget is at least 1, so reaching it implies the value held steady.
  assign qualify = (run_d == RunTarget) && !captured_q;

  // Track previous bus value, run length and whether this episode was taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      run_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      prev_q <= cur;
      run_q  <= run_d;
      if (!same) begin
        captured_q <= 1'b0;
      end else if (qualify) begin
        captured_q <= 1'b1;
      end
    end
  end

  // Segment pattern (a..g, a in MSB) to BCD digit.
  always_comb begin
    seg_ok  = 1'b1;
    seg_bcd = 4'd0;
    case (bus.sseg_indicator[6:0])
      7'b1111110: seg_bcd = 4'd0;
      7'b0110000: seg_bcd = 4'd1;
      7'b1101101: seg_bcd = 4'd2;
      7'b1111001: seg_bcd = 4'd3;
      7'b0110011: seg_bcd = 4'd4;
      7'b1011011: seg_bcd = 4'd5;
      7'b1011111: seg_bcd = 4'd6;
      7'b1110000: seg_bcd = 4'd7;
      7'b1111111: seg_bcd = 4'd8;
      7'b1111011: seg_bcd = 4'd9;
      default:    seg_ok  = 1'b0;
    endcase
  end

  // Map the tube strobe to a slot; unused tube and malformed strobes are ignored.
  always_comb begin
    slot_en  = 1'b1;
    slot_idx = 2'd0;
    case (bus.digits)
      4'b0001: slot_idx = 2'd0;
      4'b0010: slot_idx = 2'd1;
      4'b0100: slot_idx = 2'd2;
      default: slot_en  = 1'b0;
    endcase
  end

  assign frame_take = (state_q == StCollect) && (&full_q);

  // Slot next state: a frame hand-off clears the slots, but a capture on the
  // same edge still lands so no digit is lost.
  always_comb begin
    full_d = full_q;
    bcd_d  = bcd_q;
    if (frame_take) begin
      full_d = '0;
    end
    if (qualify && slot_en) begin
      full_d[slot_idx] = seg_ok;
      if (seg_ok) begin
        bcd_d[slot_idx] = seg_bcd;
      end
    end
  end

  // Slots, conversion FSM and registered result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q          <= '0;
      bcd_q           <= '0;
      state_q         <= StCollect;
      h_q             <= '0;
      t_q             <= '0;
      o_q             <= '0;
      acc7_q          <= '0;
      acc10_q         <= '0;
      address_value_q <= '0;
      address_valid_q <= 1'b0;
      decode_error_q  <= 1'b0;
      range_error_q   <= 1'b0;
    end else begin
      full_q          <= full_d;
      bcd_q           <= bcd_d;
      address_valid_q <= 1'b0;
      range_error_q   <= 1'b0;
      decode_error_q  <= qualify && slot_en && !seg_ok;
      case (state_q)
        StCollect: begin
          if (&full_q) begin
            h_q     <= bcd_q[2];
            t_q     <= bcd_q[1];
            o_q     <= bcd_q[0];
            state_q <= StConv1;
          end
        end
        StConv1: begin
          acc7_q  <= ({3'b000, h_q} << 3) + ({3'b000, h_q} << 1) + {3'b000, t_q};
          state_q <= StConv2;
        end
        StConv2: begin
          acc10_q <= ({3'b000, acc7_q} << 3) + ({3'b000, acc7_q} << 1) + {6'b000000, o_q};
          state_q <= StCheck;
        end
        StCheck: begin
          if (acc10_q <= 10'd511) begin
            address_value_q <= acc10_q[8:0];
            address_valid_q <= 1'b1;
          end else begin
            range_error_q <= 1'b1;
          end
          state_q <= StCollect;
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign bus.address_value = address_value_q;
  assign bus.address_valid = address_valid_q;
  assign bus.decode_error  = decode_error_q;
  assign bus.range_error   = range_error_q;

endmodule

// File: tb/tb_sseg_address_capture.sv
// Bench for sseg_address_capture: frame table, hand-written corner sequences and
// random bus dwells, all checked cycle by cycle against an event-level model.
module tb_sseg_address_capture;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done = 1'b0;

  sseg_address_capture_if bus ();

  sseg_address_capture #(.STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Expected events keyed by the clock edge that makes them visible.
  typedef struct packed {
    logic       v;
    logic       r;
    logic       d;
    logic       has_av;
    logic [9:0] av;
  } ev_t;

  ev_t  evs[int];
  bit   rst_at[int];
  int   exp_addr = 0;
  int   seen_valid = 0, seen_range = 0, seen_derr = 0;
  ev_t  mon_e;

  // Model state: slot digits and full flags.
  int       m_dig[3];
  bit [2:0] m_full = '0;
  logic [10:0] last_val = '0;

  typedef struct {
    int h, t, o;
    int exp_addr;
    int exp_valid;
    int exp_range;
  } frame_t;
  frame_t frames[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  function automatic ev_t get_ev(input int x);
    ev_t e;
    e = '0;
    if (evs.exists(x)) e = evs[x];
    return e;
  endfunction

  // A digit captured at edge x: fill the slot or flag an error; a completed frame
  // reports its address four edges later.
  function automatic void model_capture(input int x, input int slot, input logic [6:0] seg);
    int   dig;
    int   val;
    ev_t  e;
    dig = -1;
    for (int i = 0; i < 10; i++) if (seg_of(i) == seg) dig = i;
    if (dig < 0) begin
      m_full[slot] = 1'b0;
      e = get_ev(x);
      e.d = 1'b1;
      evs[x] = e;
    end else begin
      m_dig[slot]  = dig;
      m_full[slot] = 1'b1;
      if (m_full == 3'b111) begin
        val    = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        m_full = '0;
        e = get_ev(x + 4);
        if (val <= 511) begin
          e.v      = 1'b1;
          e.has_av = 1'b1;
          e.av     = 10'(val);
        end else begin
          e.r = 1'b1;
        end
        evs[x + 4] = e;
      end
    end
  endfunction

  function automatic void purge(input int from);
    int keys[$];
    foreach (evs[k]) if (k >= from) keys.push_back(k);
    foreach (keys[j]) evs.delete(keys[j]);
  endfunction

  // Present one bus value for n cycles; consecutive dwells always differ in [6:0]/digits.
  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    int k;
    k = edge_n;
    bus.digits         = d;
    bus.sseg_indicator = s;
    if (n >= S) begin
      case (d)
        4'b0001: model_capture(k + S, 0, s[6:0]);
        4'b0010: model_capture(k + S, 1, s[6:0]);
        4'b0100: model_capture(k + S, 2, s[6:0]);
        default: ;
      endcase
    end
    last_val = {d, s[6:0]};
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    logic [7:0] s;
    s = 8'h00;
    if (last_val == {4'b1000, 7'h00}) s = 8'h01;
    hold(4'b1000, s, n);
  endtask

  task automatic do_reset(input int n);
    purge(edge_n + 1);
    m_full = '0;
    for (int i = 0; i < n; i++) begin
      reset              = 1'b1;
      bus.digits         = 4'($urandom);
      bus.sseg_indicator = 8'($urandom);
      rst_at[edge_n + 1] = 1'b1;
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    last_val = '0;
  endtask

  task automatic run_frame(input int h, input int t, input int o);
    hold(4'b0001, {1'b0, seg_of(o)}, 9);
    hold(4'b0010, {1'b1, seg_of(t)}, 9);
    hold(4'b0100, {1'b0, seg_of(h)}, 9);
    idle(9);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (edge_n >= 1 && !done) begin
      mon_e = get_ev(edge_n);
      if (mon_e.has_av) exp_addr = int'(mon_e.av);
      if (rst_at.exists(edge_n)) begin
        exp_addr = 0;
        mon_e    = '0;
      end
      check("address_value", 32'(bus.address_value), 32'(exp_addr));
      check("address_valid", 32'(bus.address_valid), 32'(mon_e.v));
      check("range_error",   32'(bus.range_error),   32'(mon_e.r));
      check("decode_error",  32'(bus.decode_error),  32'(mon_e.d));
      if (bus.address_valid === 1'b1) seen_valid++;
      if (bus.range_error === 1'b1)   seen_range++;
      if (bus.decode_error === 1'b1)  seen_derr++;
    end
  end

  initial begin
    int v0, r0, d0;
    logic [3:0] d;
    logic [7:0] s;

    frames[0] = '{3, 1, 7, 317, 1, 0};
    frames[1] = '{3, 1, 7, 317, 1, 0};
    frames[2] = '{3, 1, 7, 317, 1, 0};
    frames[3] = '{5, 9, 9, 317, 0, 1};
    frames[4] = '{0, 0, 0,   0, 1, 0};
    frames[5] = '{5, 1, 1, 511, 1, 0};
    frames[6] = '{5, 1, 2, 511, 0, 1};
    frames[7] = '{9, 9, 9, 511, 0, 1};
    frames[8] = '{1, 2, 8, 128, 1, 0};

    reset = 1'b1;
    do_reset(3);
    check("reset address_value", 32'(bus.address_value), 32'd0);
    idle(10);

    foreach (frames[i]) begin
      v0 = seen_valid;
      r0 = seen_range;
      run_frame(frames[i].h, frames[i].t, frames[i].o);
      check("frame address_value", 32'(bus.address_value), 32'(frames[i].exp_addr));
      check("frame valid pulses", 32'(seen_valid - v0), 32'(frames[i].exp_valid));
      check("frame range pulses", 32'(seen_range - r0), 32'(frames[i].exp_range));
    end

    // Invalid tens pattern: error pulse, frame held until a good tens digit.
    v0 = seen_valid;
    d0 = seen_derr;
    hold(4'b0001, {1'b0, seg_of(7)}, 9);
    hold(4'b0010, 8'b0000_0001, 9);
    hold(4'b0100, {1'b0, seg_of(3)}, 9);
    idle(9);
    check("invalid derr pulses", 32'(seen_derr - d0), 32'd1);
    check("invalid no valid", 32'(seen_valid - v0), 32'd0);
    check("invalid addr held", 32'(bus.address_value), 32'd128);
    hold(4'b0010, {1'b0, seg_of(1)}, 9);
    idle(9);
    check("recovered valid", 32'(seen_valid - v0), 32'd1);
    check("recovered addr", 32'(bus.address_value), 32'd317);

    // Two-cycle glitch on a stable tens digit is not captured.
    v0 = seen_valid;
    d0 = seen_derr;
    hold(4'b0001, {1'b0, seg_of(7)}, 9);
    hold(4'b0010, {1'b0, seg_of(1)}, 6);
    hold(4'b0010, 8'b0111_1111, 2);
    hold(4'b0010, {1'b0, seg_of(1)}, 6);
    hold(4'b0100, {1'b0, seg_of(3)}, 9);
    idle(9);
    check("glitch valid", 32'(seen_valid - v0), 32'd1);
    check("glitch no derr", 32'(seen_derr - d0), 32'd0);
    check("glitch addr", 32'(bus.address_value), 32'd317);

    // 511 boundary, then reset during CONV2 of the following frame.
    run_frame(5, 1, 1);
    check("boundary addr", 32'(bus.address_value), 32'd511);
    v0 = seen_valid;
    hold(4'b0001, {1'b0, seg_of(2)}, 9);
    hold(4'b0010, {1'b0, seg_of(4)}, 9);
    hold(4'b0100, {1'b0, seg_of(1)}, S + 2);
    do_reset(1);
    check("abort addr", 32'(bus.address_value), 32'd0);
    idle(10);
    check("abort no valid", 32'(seen_valid - v0), 32'd0);

    // Random dwells against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: d = 4'b0001;
        3, 4, 5: d = 4'b0010;
        6, 7:    d = 4'b0100;
        8:       d = 4'b1000;
        default: d = 4'($urandom);
      endcase
      if ($urandom_range(0, 9) < 8) s = {1'($urandom), seg_of(int'($urandom_range(0, 9)))};
      else s = 8'($urandom);
      if ({d, s[6:0]} == last_val) s[0] = ~s[0];
      hold(d, s, int'($urandom_range(1, 10)));
    end
    idle(12);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_address_capture.md
# sseg_address_capture

- Decoder for the multiplexed seven-segment bus that drives the 3-digit ROM address display.
- Watches the digit strobe and segment lines, qualifies each digit after a stability window, and decodes the segment pattern to BCD.
- Once ones, tens and hundreds are captured, converts the 3-digit BCD value back to a 9-bit binary address.
- Used as a readback monitor on the display bus: for self-check of the displayed address, and as a bench scoreboard source.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical cycles of {digits, sseg_indicator[6:0]} required to accept a digit. Legal range 2..15.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- sseg_indicator  in  8  segment bus.
  - [6:0] = a..g, MSB = a.
  - [7] (dp) ignored.
- digits  in  4  tube strobe, one-hot.
  - 0001 = ones, 0010 = tens, 0100 = hundreds, 1000 = unused tube.
- address_value  out  9  last successfully decoded address; held between updates.
- address_valid  out  1  one-cycle pulse when address_value is updated.
- decode_error  out  1  one-cycle pulse on an unrecognised segment pattern on a qualified strobe.
- range_error  out  1  one-cycle pulse when a complete frame decodes to a value > 511.

## Operation
Segment decode, exact match on [6:0]:
- 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4
- 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9
- Any other pattern is invalid.

Stability filter:
- Register the previous {digits, seg[6:0]}.
- A 4-bit run counter increments while the current value equals the previous one (saturating at 15) and clears to 0 on any change.
- A strobe is qualified when the run counter reaches STABLE_CYCLES-1.
- Each strobe episode is qualified at most once; a captured flag clears only when the value changes.

Capture on a qualified strobe:
- digits = 0001, 0010 or 0100 with a valid pattern: write the BCD digit into that slot and set the slot's full bit. A rewrite of a full slot overwrites it.
- digits = 0001, 0010 or 0100 with an invalid pattern: decode_error pulses; the slot is cleared (full bit 0).
- digits = 1000, 0000, or not one-hot: ignored, no error.

FSM, states COLLECT, CONV1, CONV2, CHECK:
- COLLECT: when all three full bits are set, copy h/t/o to working registers, clear all full bits, go to CONV1. Collection continues in every state.
- CONV1: acc7 = h*10 + t, computed as (h<<3)+(h<<1)+t; max 99.
- CONV2: acc10 = acc7*10 + o; max 999, 10 bits.
- CHECK:
  - acc10 <= 511: address_value <= acc10[8:0] and address_valid pulses.
  - Otherwise: range_error pulses and address_value is unchanged.
  - Return to COLLECT.
- Captures that complete a new frame while the FSM is not in COLLECT stay in the slots and are processed on return. No frame is lost as long as one full scan takes ≥ 4 cycles.

## Timing
- Reset values:
  - address_value = 0; address_valid, decode_error, range_error = 0.
  - All slots empty, run counter 0, FSM in COLLECT.
- Capture latency: a value first present at cycle C is written to its slot at the clock edge ending cycle C+STABLE_CYCLES-1.
- Conversion latency: with the last slot written at edge E:
  - COLLECT sees all three slots full in the cycle after E.
  - CONV1 and CONV2 follow.
  - address_valid (or range_error) is high for exactly one cycle, 4 cycles after E.
- decode_error is high during the cycle after the qualifying edge.
- Simultaneous events: decode_error and address_valid/range_error may assert in the same cycle; they are independent.
- A value dwell shorter than STABLE_CYCLES produces no capture and no error.
- Reset asserted mid-conversion aborts the conversion: no pulse is produced and all state returns to reset values on the next edge.

## Test plan
- Reset: hold reset 3 cycles with random bus values -> all outputs 0; no pulses for 10 cycles after release.
- Display 317: strobe 0001/1110000, 0010/0110000, 0100/1111001, 1000/any, each held 9 cycles, repeated 3 frames -> address_value=317 and one address_valid pulse per frame, 4 cycles after the hundreds capture.
- Glitch rejection: during a stable tens digit, force seg=1111111 for 2 cycles and then restore -> no decode change, no error; address_value stays 317.
- Invalid pattern: tens strobe with 0000001 for 9 cycles -> one decode_error pulse; no address_valid until a valid tens digit is captured; then 3,1,7 -> 317.
- Range: digits 5,9,9 -> one range_error pulse, address_value keeps the prior value; then 0,0,0 -> address_value=0 with address_valid.
- Boundary and reset: 5,1,1 -> address_value=511. Then assert reset in the CONV2 cycle of the next frame -> no address_valid pulse, address_value=0 after the reset edge.
